// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and stream framing constants for the instruction-memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: collects four MSB-first bytes into a word and emits a one-cycle word_valid pulse
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic [7:0]  byte_in,
    input  logic        byte_en,
    output logic        byte_last,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sr_q, sr_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;

    assign byte_last  = cnt_q == 2'(WORD_BYTES - 1);
    assign word       = word_q;
    assign word_valid = valid_q;

    // Shift bytes in; the 4th byte snapshots the full word so a following byte cannot disturb it
    always_comb begin
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (clr) begin
            cnt_d = 2'd0;
        end else if (byte_en) begin
            cnt_d = cnt_q + 2'd1;
            sr_d  = {sr_q[15:0], byte_in};
            if (byte_last) begin
                word_d  = {sr_q, byte_in};
                valid_d = 1'b1;
            end
        end
    end

    // Packer registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= 2'd0;
            sr_q    <= 24'd0;
            word_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream boot loader writing big-endian words to imem; IMEM_LOADER_CSUM_EN adds an XOR trailer check
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        restart,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        imem_we,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [15:0] idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] hdr_n;
    logic        acc, pk_en, pk_clr, pk_last, finished;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    assign finished  = state_q == DONE || state_q == ERR;
    assign rx_ready  = !finished;
    assign acc       = rx_valid && rx_ready;
    assign pk_en     = acc && state_q == DATA;
    assign pk_clr    = restart && finished;
    assign hdr_n     = {n_q[15:8], rx_data};
    assign imem_addr = addr_q;
    assign cpu_hold  = state_q != DONE;
    assign load_done = state_q == DONE;
    assign load_err  = state_q == ERR;

    imem_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clr        (pk_clr),
        .byte_in    (rx_data),
        .byte_en    (pk_en),
        .byte_last  (pk_last),
        .word       (imem_wdata),
        .word_valid (imem_we)
    );

    // Header parsing, word counting, address stepping and load completion
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        addr_d  = imem_we ? addr_q + (32'd1 << WORD_SHIFT) : addr_q;
`ifdef IMEM_LOADER_CSUM_EN
        csum_d  = acc ? csum_q ^ rx_data : csum_q;
`endif
        case (state_q)
            HDR_HI: begin
                if (acc) begin
                    n_d     = {rx_data, 8'h00};
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                if (acc) begin
                    n_d = hdr_n;
`ifdef IMEM_LOADER_CSUM_EN
                    state_d = hdr_n == 16'd0 ? CSUM : ({1'b0, hdr_n} > MAX_N ? ERR : DATA);
`else
                    state_d = hdr_n == 16'd0 ? DONE : ({1'b0, hdr_n} > MAX_N ? ERR : DATA);
`endif
                end
            end
            DATA: begin
                if (pk_en && pk_last) idx_d = idx_q + 16'd1;
`ifdef IMEM_LOADER_CSUM_EN
                // Move on at the last byte handshake so a trailer sent back-to-back is caught
                if (pk_en && pk_last && idx_d == n_q) state_d = CSUM;
`else
                // Finish once the final word's write pulse is on the bus
                if (imem_we && idx_q == n_q) state_d = DONE;
`endif
            end
`ifdef IMEM_LOADER_CSUM_EN
            CSUM: begin
                if (acc) state_d = csum_q == rx_data ? DONE : ERR;
            end
`endif
            DONE, ERR: begin
                if (restart) begin
                    state_d = HDR_HI;
                    idx_d   = 16'd0;
                    addr_d  = BASE_ADDR;
`ifdef IMEM_LOADER_CSUM_EN
                    csum_d  = 8'd0;
`endif
                end
            end
            default: state_d = HDR_HI;
        endcase
    end

    // Loader registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= HDR_HI;
            n_q     <= 16'd0;
            idx_q   <= 16'd0;
            addr_q  <= BASE_ADDR;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule
